// File: rtl/fft_addr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fft_addr_arbiter
// Brief   : Round-robin share of one fft_address_calc among NUM_REQ requesters,
//           tagging each generated address with its owner and flagging completion.
// Revision: 1.0 - initial release
// ============================================================================
module fft_addr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int CALC_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_offset,
    input  logic [32*NUM_REQ-1:0]   req_filesize,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    busy,
    output logic [31:0]             calc_offset,
    output logic [31:0]             calc_filesize,
    output logic                    calc_enable,
    input  logic [31:0]             calc_addr,
    input  logic                    calc_done,
    output logic [31:0]             addr_out,
    output logic                    addr_valid,
    output logic [ID_W-1:0]         addr_id,
    output logic                    xfer_done,
    output logic [ID_W-1:0]         xfer_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [ID_W-1:0]                 ptr_q, ptr_d;
    logic [NUM_REQ-1:0]              grant_q, grant_d;
    logic [31:0]                     offset_q, offset_d;
    logic [31:0]                     size_q, size_d;
    logic [ID_W-1:0]                 id_q, id_d;
    logic                            done_q, done_d;
    logic [ID_W-1:0]                 xid_q, xid_d;
    logic [CALC_LAT-1:0]             vld_q, vld_d;
    logic [CALC_LAT-1:0][ID_W-1:0]   idp_q, idp_d;

    logic                            win_found;
    logic [ID_W-1:0]                 win_idx;
    logic [31:0]                     sel_off;
    logic [31:0]                     sel_size;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [ID_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_off  = '0;
        sel_size = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == ID_W'(k)) begin
                sel_off  = req_offset[k*32 +: 32];
                sel_size = req_filesize[k*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = '0;
        offset_d = offset_q;
        size_d   = size_q;
        id_d     = id_q;
        done_d   = 1'b0;
        xid_d    = xid_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d  = NUM_REQ'(1) << win_idx;
                    offset_d = sel_off;
                    size_d   = sel_size;
                    id_d     = win_idx;
                    ptr_d    = win_idx;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (size_q == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (calc_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Completion is reported only once the last beat has left the pipe.
                if (vld_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    xid_d   = id_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid/ID pipe mirrors the calculator latency so tags line up with addresses.
    always_comb begin
        vld_d    = '0;
        idp_d    = '0;
        vld_d[0] = calc_enable & (state_q == S_RUN);
        idp_d[0] = id_q;
        for (int i = 1; i < CALC_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idp_d[i] = idp_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= ID_W'(NUM_REQ - 1);
            grant_q  <= '0;
            offset_q <= '0;
            size_q   <= '0;
            id_q     <= '0;
            done_q   <= 1'b0;
            xid_q    <= '0;
            vld_q    <= '0;
            idp_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            offset_q <= offset_d;
            size_q   <= size_d;
            id_q     <= id_d;
            done_q   <= done_d;
            xid_q    <= xid_d;
            vld_q    <= vld_d;
            idp_q    <= idp_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q != S_IDLE);
    assign calc_offset   = offset_q;
    assign calc_filesize = size_q;
    assign calc_enable   = (state_q == S_RUN);
    assign addr_valid    = vld_q[CALC_LAT-1];
    assign addr_id       = idp_q[CALC_LAT-1];
    // Forwarded address is zeroed outside valid beats so nothing stale leaks out.
    assign addr_out      = addr_valid ? calc_addr : '0;
    assign xfer_done     = done_q;
    assign xfer_id       = xid_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_addr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_addr_arbiter
// Brief   : Self-checking bench: behavioural calculator plus a scoreboard model
//           of round-robin grants, per-transfer beat lists and completions.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_addr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic [32*N-1:0]    req_offset;
    logic [32*N-1:0]    req_filesize;
    logic [N-1:0]       grant;
    logic               busy;
    logic [31:0]        calc_offset;
    logic [31:0]        calc_filesize;
    logic               calc_enable;
    logic [31:0]        calc_addr;
    logic               calc_done;
    logic [31:0]        addr_out;
    logic               addr_valid;
    logic [IDW-1:0]     addr_id;
    logic               xfer_done;
    logic [IDW-1:0]     xfer_id;
    logic               spur;

    fft_addr_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CALC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_offset(req_offset),
        .req_filesize(req_filesize), .grant(grant), .busy(busy),
        .calc_offset(calc_offset), .calc_filesize(calc_filesize),
        .calc_enable(calc_enable), .calc_addr(calc_addr), .calc_done(calc_done),
        .addr_out(addr_out), .addr_valid(addr_valid), .addr_id(addr_id),
        .xfer_done(xfer_done), .xfer_id(xfer_id)
    );

    always #5 clk = ~clk;

    // Behavioural address calculator: count per enabled cycle, address LAT later.
    logic [31:0] cnt;
    logic [31:0] apipe [LAT];
    always @(posedge clk) begin
        if (rst || !calc_enable) cnt <= 32'd0;
        else                     cnt <= cnt + 32'd1;
        apipe[0] <= calc_offset + (cnt << 2);
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign calc_addr = apipe[LAT-1];
    assign calc_done = (calc_enable && (cnt == calc_filesize - 32'd1)) || spur;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs as the DUT saw them on the most recent rising edge.
    logic            rst_s = 1'b1;
    logic [N-1:0]    req_s;
    logic [32*N-1:0] off_s, size_s;
    int              cyc = 0;
    always @(posedge clk) begin
        rst_s  <= rst;
        req_s  <= req;
        off_s  <= req_offset;
        size_s <= req_filesize;
        cyc    <= cyc + 1;
    end

    // Reference model state
    int          m_ptr = N - 1;
    bit          active = 1'b0;
    int          exp_id = 0;
    bit          zero_len = 1'b0;
    int          gcyc = 0;
    int          m_w;
    logic [31:0] m_off, m_sz;
    logic [31:0] qa[$];
    int          qi[$];
    int          gseq[$];
    int          beat_cnt = 0;
    int          done_cnt = 0;
    logic [N-1:0] gseen = '0;

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst_s) begin
            check("rst_ctl", {grant, busy, calc_enable, addr_valid, xfer_done}, 64'd0);
            check("rst_ops", {calc_offset, calc_filesize}, 64'd0);
            qa.delete();
            qi.delete();
            active = 1'b0;
            m_ptr  = N - 1;
            gseen  = '0;
        end else begin
            if (grant != '0) begin
                m_w = rr_pick(m_ptr, req_s);
                check("grant", grant, (m_w < 0) ? 64'd0 : (64'd1 << m_w));
                check("grant_while_active", active, 1'b0);
                if (m_w >= 0) begin
                    m_ptr    = m_w;
                    active   = 1'b1;
                    exp_id   = m_w;
                    m_off    = off_s[32*m_w +: 32];
                    m_sz     = size_s[32*m_w +: 32];
                    zero_len = (m_sz == 32'd0);
                    gcyc     = cyc;
                    gseen[m_w] = 1'b1;
                    gseq.push_back(m_w);
                    for (int k = 0; k < int'(m_sz); k++) begin
                        qa.push_back(m_off + 32'(4 * k));
                        qi.push_back(m_w);
                    end
                end
            end
            if (addr_valid) begin
                check("beat_owed", qa.size() > 0, 1'b1);
                if (qa.size() > 0) begin
                    check("addr", addr_out, qa.pop_front());
                    check("addr_id", addr_id, qi.pop_front());
                    check("busy_beat", busy, 1'b1);
                end
                beat_cnt++;
            end
            if (xfer_done) begin
                check("done_active", active, 1'b1);
                check("xfer_id", xfer_id, exp_id);
                check("beats_left", qa.size(), 0);
                check("busy_after_done", busy, 1'b0);
                if (zero_len) check("zero_len_latency", cyc - gcyc, 2);
                active = 1'b0;
                done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int i, input logic [31:0] off, input logic [31:0] sz);
        req_offset[32*i +: 32]   = off;
        req_filesize[32*i +: 32] = sz;
        req[i]   = 1'b1;
        gseen[i] = 1'b0;
    endtask

    task automatic release_granted();
        for (int i = 0; i < N; i++) begin
            if (req[i] && gseen[i]) begin
                req[i]   = 1'b0;
                gseen[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int n, input bit hold);
        int budget;
        budget = 400;
        while (done_cnt < n && budget > 0) begin
            tick();
            if (!hold) release_granted();
            budget--;
        end
        if (budget == 0) check("timeout_done", done_cnt, n);
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while ((busy || active || req != '0) && budget > 0) begin
            tick();
            release_granted();
            budget--;
        end
        if (budget == 0) check("timeout_drain", {busy, active}, 2'b00);
        tick();
    endtask

    int base;
    int exp2[5] = '{0, 1, 2, 3, 0};
    int exp4[3] = '{3, 0, 3};

    initial begin
        rst = 1'b1; req = '0; spur = 1'b0;
        req_offset = '0; req_filesize = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Contention from reset: all four held, two words each.
        base = gseq.size();
        for (int i = 0; i < N; i++) do_req(i, 32'h100 * (i + 1), 32'd2);
        wait_done(done_cnt + 5, 1'b1);
        req = '0;
        drain();
        check("rr_count", (gseq.size() - base) >= 5, 1'b1);
        if (gseq.size() - base >= 5)
            for (int k = 0; k < 5; k++) check("rr_order", gseq[base+k], exp2[k]);

        // Single transfer.
        do_req(1, 32'h1000, 32'd4);
        wait_done(done_cnt + 1, 1'b0);
        drain();
        check("single_owner", gseq[gseq.size()-1], 1);

        // Zero length.
        do_req(2, 32'h3000, 32'd0);
        wait_done(done_cnt + 1, 1'b0);
        drain();

        // Pointer wrap: grant 3, then 1001 gives 0 then 3.
        base = gseq.size();
        do_req(3, 32'h4000, 32'd1);
        wait_done(done_cnt + 1, 1'b0);
        do_req(0, 32'h5000, 32'd2);
        do_req(3, 32'h6000, 32'd2);
        wait_done(done_cnt + 2, 1'b0);
        drain();
        check("wrap_count", gseq.size() - base, 3);
        if (gseq.size() - base == 3)
            for (int k = 0; k < 3; k++) check("wrap_order", gseq[base+k], exp4[k]);

        // Spurious done in IDLE alone.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        check("spur_idle_busy", busy, 1'b0);
        // Spurious done across IDLE and LOAD must not shorten the transfer.
        spur = 1'b1;
        do_req(2, 32'h7000, 32'd3);
        tick();
        tick();
        spur = 1'b0;
        wait_done(done_cnt + 1, 1'b0);
        drain();

        // Reset after five beats of a sixteen-word transfer.
        base = beat_cnt;
        do_req(0, 32'h2000, 32'd16);
        begin
            int budget;
            budget = 100;
            while (beat_cnt < base + 5 && budget > 0) begin
                tick();
                release_granted();
                budget--;
            end
            if (budget == 0) check("timeout_beats", beat_cnt - base, 5);
        end
        base = done_cnt;
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("no_done_on_rst", done_cnt, base);
        do_req(0, 32'h2000, 32'd16);
        wait_done(done_cnt + 1, 1'b0);
        drain();
        check("post_rst_owner", gseq[gseq.size()-1], 0);

        // Randomized traffic, requests re-raised straight after grant at times.
        for (int c = 0; c < 1500 && done_cnt < 80; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (req[i] && gseen[i]) begin
                    gseen[i] = 1'b0;
                    if ($urandom % 2 == 0) do_req(i, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 5));
                    else req[i] = 1'b0;
                end else if (!req[i] && ($urandom % 4 == 0)) begin
                    do_req(i, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 5));
                end
            end
        end
        req = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
